// File: rtl/julia_iter_engine.sv
// julia_iter_engine: per-pixel Julia z <- z^2 + c iterator in signed Q16.16, one step per clock.
// Define JULIA_LOG_INTENSITY_EN for piecewise-linear log2 intensity instead of the linear ramp.
module julia_iter_engine #(
  parameter logic [15:0] MAX_ITER = 16'd100,
  parameter logic [31:0] ESCAPE   = 32'h0005_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic [31:0] z_real,
  input  logic [31:0] z_imag,
  input  logic [31:0] c_real,
  input  logic [31:0] c_imag,
  output logic        done,
  output logic        busy,
  output logic [7:0]  intensity,
  output logic [15:0] iter_count
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_nx;
  logic signed [31:0] zr, zi, cr, ci, zr_nx, zi_nx;
  logic [31:0] abs_r, abs_i;
  logic [33:0] mag;
  logic        esc, fin;
  logic [15:0] n, m;
  logic [7:0]  mapped;
  always_comb begin
    abs_r = zr[31] ? 32'(-zr) : zr;
    abs_i = zi[31] ? 32'(-zi) : zi;
    mag = {2'b0, abs_r} + {2'b0, abs_i};
    esc = mag > {2'b0, ESCAPE};
    fin = state == ITER && start && (esc || n == MAX_ITER);
    zr_nx = 32'((64'(zr) * 64'(zr)) >>> 16) - 32'((64'(zi) * 64'(zi)) >>> 16) + cr;
    zi_nx = 32'((64'(zr) * 64'(zi)) >>> 15) + ci;
    m = n + 16'd1;
  end
`ifdef JULIA_LOG_INTENSITY_EN
  logic [3:0] p;
  always_comb begin
    p = 4'd0;
    for (int i = 1; i < 16; i++) if (m[i]) p = 4'(i);
  end
  // the four bits under the MSB land in [3:0] after the shift, zero-padded for small m
  assign mapped = {p, 4'({m, 4'b0} >> p)};
`else
  assign mapped = m > 16'd255 ? 8'hff : m[7:0];
`endif
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ITER : IDLE;
      ITER:    state_nx = !start ? IDLE : (esc || n == MAX_ITER) ? DONE : ITER;
      DONE:    state_nx = start ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    done = state == DONE;
    busy = state == ITER;
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      zr <= '0;
      zi <= '0;
      cr <= '0;
      ci <= '0;
      n <= '0;
      intensity <= '0;
      iter_count <= '0;
    end else begin
      if (state == IDLE && start) begin
        zr <= z_real;
        zi <= z_imag;
        cr <= c_real;
        ci <= c_imag;
        n <= '0;
      end else if (state == ITER && start && !fin) begin
        zr <= zr_nx;
        zi <= zi_nx;
        n <= m;
      end
      if (fin) begin
        iter_count <= n;
        intensity <= esc ? mapped : 8'd0;
      end
    end
endmodule

// File: tb/tb_julia_iter_engine.sv
// tb_julia_iter_engine: scoreboard bench for julia_iter_engine (default MAX_ITER=100, ESCAPE=5.0).
module tb_julia_iter_engine;
  logic        CLK = 0, RESET_N = 0, start = 0;
  logic [31:0] z_real = 0, z_imag = 0, c_real = 0, c_imag = 0;
  logic        done, busy;
  logic [7:0]  intensity;
  logic [15:0] iter_count;
  typedef struct {int n; logic [7:0] inten;} exp_t;
  exp_t sb[$];
  int checks = 0, fails = 0, last_n = 0;
  logic [7:0] last_int = 0;

  julia_iter_engine dut (.CLK(CLK), .RESET_N(RESET_N), .start(start), .z_real(z_real), .z_imag(z_imag),
    .c_real(c_real), .c_imag(c_imag), .done(done), .busy(busy), .intensity(intensity), .iter_count(iter_count));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] map_int(input int n, input bit esc);
    int m, p;
    if (!esc) return 8'd0;
    m = n + 1;
`ifdef JULIA_LOG_INTENSITY_EN
    p = 0;
    for (int i = 0; i < 16; i++) if ((m >> i) != 0) p = i;
    return 8'((p << 4) | ((p >= 4 ? (m >> (p - 4)) : (m << (4 - p))) & 15));
`else
    return 8'(m > 255 ? 255 : m);
`endif
  endfunction

  function automatic void model(input int zr0, input int zi0, input int cr, input int ci,
                                output int n, output bit esc);
    int zr = zr0, zi = zi0, tr;
    longint ar, ai;
    for (n = 0; n <= 100; n++) begin
      ar = zr < 0 ? -longint'(zr) : longint'(zr);
      ai = zi < 0 ? -longint'(zi) : longint'(zi);
      if (ar + ai > 64'd327680) begin esc = 1; return; end
      if (n == 100) begin esc = 0; return; end
      tr = int'((longint'(zr) * longint'(zr)) >>> 16) - int'((longint'(zi) * longint'(zi)) >>> 16) + cr;
      zi = int'((longint'(zr) * longint'(zi)) >>> 15) + ci;
      zr = tr;
    end
    esc = 0;
    n = 100;
  endfunction

  task automatic run_pixel(input int zr, input int zi, input int cr, input int ci,
                           input int en, input bit esc, input int hold);
    exp_t e;
    int cyc = 0, bcyc = 0, hcyc = 0;
    sb.push_back('{en, map_int(en, esc)});
    @(negedge CLK);
    z_real = zr; z_imag = zi; c_real = cr; c_imag = ci; start = 1;
    do begin
      @(posedge CLK); cyc++;
      @(negedge CLK); if (busy) bcyc++;
    end while (!done && cyc < 400);
    check("timeout", {31'b0, done}, 1);
    e = sb.pop_front();
    check("iter_count", {16'b0, iter_count}, e.n);
    check("intensity", {24'b0, intensity}, e.inten);
    check("latency", cyc, e.n + 2);
    check("busy_cycles", bcyc, e.n + 1);
    last_n = e.n; last_int = e.inten;
    repeat (hold) begin
      @(posedge CLK); @(negedge CLK);
      if (done && !busy) hcyc++;
    end
    if (hold > 0) check("hold_done", hcyc, hold);
    start = 0;
    @(posedge CLK); @(negedge CLK);
    check("done_fall", {31'b0, done}, 0);
  endtask

  localparam int ONE = 65536;

  initial begin
    int rn, zr, zi, cr, ci;
    bit re;
    repeat (2) @(negedge CLK);
    check("rst_done", {31'b0, done}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_intensity", {24'b0, intensity}, 0);
    check("rst_iter", {16'b0, iter_count}, 0);
    RESET_N = 1;
    run_pixel(6 * ONE, 0, 0, 0, 0, 1, 5);
    run_pixel(2 * ONE, 0, 0, 0, 2, 1, 0);
    run_pixel(5 * ONE, 0, 0, 0, 1, 1, 0);
    run_pixel(-98304, -98304, 0, 0, 2, 1, 0);
    run_pixel(0, 0, 0, 0, 100, 0, 0);
    // abort mid-ITER: done never rises and results keep the previous pixel
    @(negedge CLK);
    z_real = 0; z_imag = 0; c_real = 0; c_imag = 0; start = 1;
    repeat (4) @(posedge CLK);
    @(negedge CLK); start = 0;
    @(posedge CLK); @(negedge CLK);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_iter", {16'b0, iter_count}, last_n);
    check("abort_int", {24'b0, intensity}, last_int);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("abort_done_late", {31'b0, done}, 0);
    // async reset between edges mid-ITER
    run_pixel(2 * ONE, 0, 0, 0, 2, 1, 0);
    @(negedge CLK); start = 1;
    z_real = 0; z_imag = 0;
    repeat (5) @(posedge CLK);
    #2 RESET_N = 0;
    #1;
    check("arst_done", {31'b0, done}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_int", {24'b0, intensity}, 0);
    check("arst_iter", {16'b0, iter_count}, 0);
    start = 0;
    @(negedge CLK); RESET_N = 1;
    run_pixel(2 * ONE, 0, 0, 0, 2, 1, 0);
    for (int k = 0; k < 8; k++) begin
      zr = int'($urandom_range(0, 262144)) - 131072;
      zi = int'($urandom_range(0, 262144)) - 131072;
      cr = int'($urandom_range(0, 131072)) - 65536;
      ci = int'($urandom_range(0, 131072)) - 65536;
      model(zr, zi, cr, ci, rn, re);
      run_pixel(zr, zi, cr, ci, rn, re, 0);
    end
    model(-98304, -98304, 0, 0, rn, re);
    check("model_sanity", rn, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/julia_iter_engine.md
Name: julia_iter_engine

Overview:
- Per-pixel Julia iteration responder; the pixel scanner drives start/z/c and waits for done.
- Iterates z <- z^2 + c in signed Q16.16, one iteration per clock, until escape or MAX_ITER.
- Returns an 8-bit intensity and the iteration count to the scanner, which writes the pixel to the frame buffer.

Parameters:
- MAX_ITER, 100, iteration limit; 16-bit unsigned, range 1..65534.
- ESCAPE, 32'h0005_0000, escape threshold in Q16.16 (5.0), compared against |zr|+|zi|.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  request level; 4-phase handshake with done.
- z_real  in  32  signed Q16.16 initial z real part; sampled with start.
- z_imag  in  32  signed Q16.16 initial z imaginary part.
- c_real  in  32  signed Q16.16 Julia constant, real part.
- c_imag  in  32  signed Q16.16 Julia constant, imaginary part.
- done  out  1  result valid; held until start is low.
- busy  out  1  high in ITER.
- intensity  out  8  pixel intensity; valid while done is high.
- iter_count  out  16  iterations completed before termination; valid while done is high.

Behaviour:
- Reset (async, RESET_N=0): state=IDLE; done=0, busy=0, intensity=0, iter_count=0; internal z, c and n cleared. Reset in any state aborts immediately.
- FSM states: IDLE, ITER, DONE.
- IDLE: on a clock edge with start=1, latch z_real, z_imag, c_real and c_imag; set n=0; go to ITER.
- ITER, each edge, evaluated in this priority order:
  - If start=0: abort and go to IDLE. done is not raised and outputs are unchanged.
  - Escape test: a = |zr| + |zi|, computed 34-bit unsigned (abs of 0x8000_0000 = 2^31, no overflow). If a > ESCAPE (strict), record n and escaped=1, go to DONE.
  - Else if n == MAX_ITER: record n and escaped=0, go to DONE.
  - Else update z and set n <= n+1.
- Update arithmetic:
  - zr' = (zr*zr)[47:16] - (zi*zi)[47:16] + cr.
  - zi' = (zr*zi)[46:15] + ci.
  - Products are full 64-bit signed; the bit selects truncate toward minus infinity.
  - Additions wrap modulo 2^32 with no saturation.
- Latency: start sampled at edge k; done rises after edge k+n+1, where n is the final count. Worst case is k+MAX_ITER+1.
- DONE:
  - done=1; intensity and iter_count are stable.
  - Leave for IDLE on the first edge with start=0; done falls after that edge.
  - A new request needs start to go low and then high again. start held high in DONE never re-triggers.
- Intensity, default mapping:
  - Escaped: intensity = min(n+1, 255).
  - Not escaped: intensity = 0.
- busy=1 exactly while in ITER.

Optional Feature:
- Macro: JULIA_LOG_INTENSITY_EN.
- Defined: escaped intensity is a piecewise-linear log2 of m = n+1 (16-bit).
  - intensity[7:4] = position of m's MSB.
  - intensity[3:0] = the up-to-4 bits directly below the MSB, left-aligned and zero-padded.
  - Examples: m=1 -> 0x00; m=8 -> 0x30; m=12 -> 0x38.
  - Non-escaped pixels still give 0.
- Undefined: linear mapping as in Behaviour. Handshake, latency and iter_count are identical either way.

Test Plan:
- c=0, z=(6.0,0), start held -> escape at n=0; done after edge k+1; iter_count=0, intensity=1 (log mode 0x00).
- c=0, z=(2.0,0) -> z goes 2, 4, 16; escape at n=2; iter_count=2, intensity=3; done after edge k+3. Also c=0, z=(5.0,0) -> no escape at n=0 (exactly 5.0), escape at n=1.
- c=0, z=(-1.5,-1.5) -> iterates to (0, 4.5), then (-20.25, 0); escape at n=2, intensity=3; covers signed truncation.
- c=0, z=0 -> never escapes; iter_count=100, intensity=0; done after edge k+101; busy high for exactly 101 cycles.
- Handshake:
  - Hold start high 5 cycles after done -> done stays high and no restart.
  - Drop start -> done falls next edge.
  - Drop start mid-ITER -> IDLE, done never asserted.
- Assert RESET_N=0 asynchronously mid-ITER (between edges) -> done, busy, intensity and iter_count are 0 immediately; the next start runs a clean computation.
